// File: rtl/pb_tile_launch_ctrl.sv
// pb_tile_launch_ctrl: autonomous tile launch sequencer.
// Writes per-tile clock/reset/entry registers, then polls EOC.
module pb_tile_launch_ctrl #(
  parameter int unsigned          NumTiles   = 16,
  parameter int unsigned          AddrWidth  = 48,
  parameter logic [AddrWidth-1:0] TileBase   = 48'h0000_2000_0000,
  parameter logic [AddrWidth-1:0] TileStride = 48'h0000_0004_0000,
  parameter logic [AddrWidth-1:0] OffClkEn   = 48'h00,
  parameter logic [AddrWidth-1:0] OffRst     = 48'h04,
  parameter logic [AddrWidth-1:0] OffEntryLo = 48'h08,
  parameter logic [AddrWidth-1:0] OffEntryHi = 48'h0C,
  parameter logic [AddrWidth-1:0] EocAddr    = 48'h0000_0300_0008,
  parameter int unsigned          PollGap    = 64,
  parameter int unsigned          Timeout    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [NumTiles-1:0]  tile_mask_i,
  input  logic [63:0]          entry_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [30:0]          exit_code_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [AddrWidth-1:0] req_addr_o,
  output logic                 req_write_o,
  output logic [31:0]          req_wdata_o,
  input  logic                 rsp_valid_i,
  input  logic [31:0]          rsp_rdata_i,
  input  logic                 rsp_error_i
);

  localparam int unsigned IdxW =
    (NumTiles > 1) ? $clog2(NumTiles) : 1;

  typedef enum logic [3:0] {
    IDLE, CLKEN, RSTREL, ENTLO, ENTHI,
    NEXT, POLL, GAP, DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [NumTiles-1:0]  rem_q, rem_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [63:0]          entry_q, entry_d;
  logic [30:0]          exit_q, exit_d;
  logic                 err_q, err_d;
  logic [31:0]          poll_q, poll_d;
  logic [31:0]          gap_q, gap_d;
  logic [31:0]          poll_inc;
  logic [AddrWidth-1:0] base;
  logic                 bus_st;

  function automatic logic [IdxW-1:0] low_idx(
    input logic [NumTiles-1:0] m
  );
    low_idx = '0;
    for (int i = NumTiles - 1; i >= 0; i--)
      if (m[i]) low_idx = IdxW'(i);
  endfunction

  assign base = TileBase
              + AddrWidth'(idx_q) * TileStride;
  assign bus_st = state_q inside
    {CLKEN, RSTREL, ENTLO, ENTHI, POLL};
  assign poll_inc = (poll_q == '1) ? poll_q
                                   : poll_q + 32'd1;

  assign busy_o      = state_q != IDLE;
  assign done_o      = state_q == DONE;
  assign error_o     = done_o & err_q;
  assign exit_code_o = exit_q;
  // pend_q marks the single outstanding transaction
  assign req_valid_o = bus_st & ~pend_q;
  assign req_write_o = req_valid_o
                     & (state_q != POLL);

  always_comb begin
    req_addr_o  = '0;
    req_wdata_o = '0;
    if (req_valid_o) begin
      unique case (state_q)
        CLKEN: begin
          req_addr_o  = base + OffClkEn;
          req_wdata_o = 32'd1;
        end
        RSTREL: req_addr_o = base + OffRst;
        ENTLO: begin
          req_addr_o  = base + OffEntryLo;
          req_wdata_o = entry_q[31:0];
        end
        ENTHI: begin
          req_addr_o  = base + OffEntryHi;
          req_wdata_o = entry_q[63:32];
        end
        POLL: req_addr_o = EocAddr;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    exit_d  = exit_q;
    err_d   = err_q;
    poll_d  = poll_q;
    gap_d   = gap_q;
    if (req_valid_o && req_ready_i) pend_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          // rem holds the mask with the current tile removed
          rem_d   = tile_mask_i
                  & (tile_mask_i - NumTiles'(1));
          idx_d   = low_idx(tile_mask_i);
          entry_d = entry_i;
          exit_d  = '0;
          err_d   = 1'b0;
          poll_d  = '0;
          gap_d   = '0;
          state_d = (tile_mask_i == '0) ? POLL
                                        : CLKEN;
        end
      end
      NEXT: begin
        if (rem_q == '0) begin
          state_d = POLL;
        end else begin
          idx_d   = low_idx(rem_q);
          rem_d   = rem_q & (rem_q - NumTiles'(1));
          state_d = CLKEN;
        end
      end
      GAP: begin
        if (gap_q == 32'(PollGap - 1)) begin
          gap_d   = '0;
          state_d = POLL;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (pend_q && rsp_valid_i) begin
      pend_d = 1'b0;
      if (rsp_error_i) begin
        err_d   = 1'b1;
        exit_d  = '0;
        state_d = DONE;
      end else begin
        unique case (state_q)
          CLKEN:  state_d = RSTREL;
          RSTREL: state_d = ENTLO;
          ENTLO:  state_d = ENTHI;
          ENTHI:  state_d = NEXT;
          POLL: begin
            if (rsp_rdata_i[0]) begin
              exit_d  = rsp_rdata_i[31:1];
              state_d = DONE;
            end else begin
              poll_d  = poll_inc;
              state_d = GAP;
              if (Timeout != 0 &&
                  poll_inc == 32'(Timeout)) begin
                err_d   = 1'b1;
                state_d = DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      rem_q   <= '0;
      idx_q   <= '0;
      entry_q <= '0;
      exit_q  <= '0;
      err_q   <= 1'b0;
      poll_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
      poll_q  <= poll_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_pb_tile_launch_ctrl.sv
// tb_pb_tile_launch_ctrl: directed launch scenarios against a
// bus responder and a transaction-level model of the traffic.
`timescale 1ns/1ps
module tb_pb_tile_launch_ctrl;

  localparam int unsigned PollGapTb = 64;
  localparam int unsigned TimeoutTb = 4;
  localparam logic [47:0] TBase   = 48'h0000_2000_0000;
  localparam logic [47:0] TStride = 48'h0000_0004_0000;
  localparam logic [47:0] Eoc     = 48'h0000_0300_0008;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] mask;
  logic [63:0] entry;
  logic        busy, done, error;
  logic [30:0] exit_code;
  logic        req_valid, req_write;
  logic        req_ready = 1'b0;
  logic [47:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_error = 1'b0;

  pb_tile_launch_ctrl #(
    .PollGap(PollGapTb),
    .Timeout(TimeoutTb)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .tile_mask_i(mask),
    .entry_i(entry),
    .busy_o(busy),
    .done_o(done),
    .error_o(error),
    .exit_code_o(exit_code),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_addr_o(req_addr),
    .req_write_o(req_write),
    .req_wdata_o(req_wdata),
    .rsp_valid_i(rsp_valid),
    .rsp_rdata_i(rsp_rdata),
    .rsp_error_i(rsp_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] addr;
    logic        wr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        got_q[$];
  logic [31:0] eoc_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          t_start = 0;
  int          last_cyc = 0;
  int          n_acc = 0;
  int          rd_n = 0;
  int          err_idx = -1;
  int          stall_left = 0;
  bit          run = 0;
  bit          have_last = 0;
  bit          done_seen = 0;
  bit          sched = 0;
  bit          s_err = 0;
  bit          s_last = 0;
  bit          stalled = 0;
  bit          stall_en = 0;
  bit          exp_err = 0;
  logic [30:0] exp_exit = '0;
  logic [31:0] s_data = '0;
  logic [47:0] st_addr = '0;
  logic        st_wr = 1'b0;
  logic [31:0] st_data = '0;
  logic        exp_d;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name,
                              logic [95:0] act,
                              logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, req, cyc);
    end
  endfunction

  function automatic void push(logic [47:0] a, logic w,
                               logic [31:0] d);
    exp_q.push_back('{a, w, d, 0});
  endfunction

  // Expected traffic: 4 writes per selected tile in ascending
  // order, then EOC reads until bit0 or the poll limit.
  function automatic void build_exp(logic [15:0] m,
                                    logic [63:0] e, int eidx);
    logic [47:0] b;
    logic [31:0] d;
    exp_q.delete();
    exp_err  = 0;
    exp_exit = '0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        b = TBase + TStride * 48'(i);
        push(b + 48'h0, 1'b1, 32'd1);
        push(b + 48'h4, 1'b1, 32'd0);
        push(b + 48'h8, 1'b1, e[31:0]);
        push(b + 48'hC, 1'b1, e[63:32]);
      end
    end
    for (int k = 0; k < 1000; k++) begin
      push(Eoc, 1'b0, 32'd0);
      d = (k < eoc_q.size()) ? eoc_q[k] : 32'd0;
      if (d[0]) begin
        exp_exit = d[31:1];
        break;
      end
      if (k + 1 == int'(TimeoutTb)) begin
        exp_err = 1;
        break;
      end
    end
    if (eidx >= 0 && eidx < exp_q.size()) begin
      while (exp_q.size() > eidx + 1) void'(exp_q.pop_back());
      exp_err  = 1;
      exp_exit = '0;
    end
  endfunction

  // Bus responder and per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_valid = 0;
        rsp_error = 0;
        req_ready = 0;
        sched     = 0;
        stalled   = 0;
      end else begin
        rsp_valid = sched;
        rsp_rdata = s_data;
        rsp_error = s_err;
        if (sched && s_last) begin
          have_last = 1;
          last_cyc  = cyc;
        end
        if (run) begin
          exp_d = have_last && (cyc == last_cyc + 1);
          if (sched) chk("one_outstanding", req_valid, 0);
          if (stalled)
            chk("stall_hold",
                {req_valid, req_write, req_addr, req_wdata},
                {1'b1, st_wr, st_addr, st_data});
          if (cyc == t_start + 1) begin
            chk("first_req", req_valid, 1);
            chk("exit_clear", exit_code, 0);
          end
          chk("busy", busy, (cyc > t_start) &&
              (!have_last || cyc <= last_cyc + 1));
          chk("done", done, exp_d);
          chk("error", error, exp_d && exp_err);
          if (exp_d) chk("exit_code", exit_code, exp_exit);
          if (have_last && cyc > last_cyc)
            chk("req_after_end", req_valid, 0);
        end
        if (done) done_seen = 1;
        sched     = 0;
        stalled   = 0;
        req_ready = 0;
        if (req_valid) begin
          if (stall_left > 0) begin
            stall_left--;
            stalled = 1;
            st_addr = req_addr;
            st_wr   = req_write;
            st_data = req_wdata;
          end else begin
            req_ready = 1;
            got_q.push_back('{req_addr, req_write,
                              req_write ? req_wdata : 32'h0, cyc});
            sched  = 1;
            s_err  = (n_acc == err_idx);
            s_last = (n_acc == exp_q.size() - 1);
            s_data = 32'h0;
            if (!req_write) begin
              if (rd_n < eoc_q.size()) s_data = eoc_q[rd_n];
              rd_n++;
            end
            n_acc++;
            stall_left = stall_en ? $urandom_range(0, 10) : 0;
          end
        end
      end
    end
  end

  task automatic start_run(input logic [15:0] m,
                           input logic [63:0] e,
                           input int eidx, input bit stl);
    err_idx  = eidx;
    stall_en = stl;
    build_exp(m, e, eidx);
    got_q.delete();
    n_acc      = 0;
    rd_n       = 0;
    have_last  = 0;
    done_seen  = 0;
    stall_left = stl ? $urandom_range(1, 10) : 0;
    @(negedge clk);
    #1;
    start   = 1;
    mask    = m;
    entry   = e;
    t_start = cyc;
    run     = 1;
    @(negedge clk);
    #1;
    start = 0;
    mask  = '1;
    entry = '1;
  endtask

  task automatic finish_run(input string tag);
    for (int i = 0; i < 2000 && !done_seen; i++)
      @(posedge clk);
    chk({tag, "_done_wait"}, done_seen, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    run = 0;
    chk({tag, "_ntxn"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_txn%0d", tag, k),
          {got_q[k].addr, got_q[k].wr, got_q[k].data},
          {exp_q[k].addr, exp_q[k].wr, exp_q[k].data});
    for (int k = 1; k < got_q.size(); k++)
      if (!got_q[k].wr && !got_q[k-1].wr)
        chk({tag, "_poll_gap"},
            (got_q[k].cyc - got_q[k-1].cyc) >= int'(PollGapTb), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    start = 0;
    mask  = '0;
    entry = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs",
        {busy, done, error, req_valid, req_write,
         exit_code, req_addr, req_wdata}, 0);
    rst_n = 1;

    // two tiles, EOC on the third read
    eoc_q = '{32'h0, 32'h0, 32'h2B};
    start_run(16'h0005, 64'h8000_0000_0000_1000, -1, 0);
    chk("model_len", exp_q.size(), 11);
    chk("model_tile2", exp_q[4].addr, 48'h0000_2008_0000);
    chk("model_exit", exp_exit, 21);
    finish_run("t1");
    chk("t1_exit_held", exit_code, 31'd21);
    if (got_q.size() > 7)
      chk("t1_hi", {got_q[7].addr, got_q[7].data},
          {48'h0000_2008_000C, 32'h8000_0000});

    // empty mask: straight to polling
    eoc_q = '{32'h1};
    start_run(16'h0000, 64'h0, -1, 0);
    chk("model_empty_len", exp_q.size(), 1);
    finish_run("t2");

    // same launch as t1 under random ready stalls
    eoc_q = '{32'h0, 32'h0, 32'h2B};
    start_run(16'h0005, 64'h8000_0000_0000_1000, -1, 1);
    finish_run("t3");
    chk("t3_exit", exit_code, 31'd21);

    // bus error on tile 1 reset-release write
    eoc_q = '{32'h1};
    start_run(16'h0003, 64'h0000_0000_0000_2000, 5, 0);
    chk("model_err_len", exp_q.size(), 6);
    finish_run("t4");
    chk("t4_exit", exit_code, 31'd0);

    // EOC never set: poll limit
    eoc_q.delete();
    start_run(16'h0000, 64'h0, -1, 0);
    chk("model_to_len", exp_q.size(), 4);
    finish_run("t5");

    // top tile only, full-width exit code
    eoc_q = '{32'hFFFF_FFFF};
    start_run(16'h8000, 64'h0123_4567_89AB_CDEF, -1, 0);
    finish_run("t7");
    chk("t7_exit", exit_code, 31'h7FFF_FFFF);
    if (got_q.size() > 0)
      chk("t7_addr", got_q[0].addr, 48'h0000_203C_0000);

    // every tile
    eoc_q = '{32'h0, 32'h3};
    start_run(16'hFFFF, 64'hDEAD_BEEF_CAFE_F00D, -1, 0);
    finish_run("t8");
    chk("t8_exit", exit_code, 31'd1);

    // reset during GAP with an ignored start while busy
    eoc_q.delete();
    start_run(16'h0001, 64'h0000_0000_4000_0000, -1, 0);
    for (int i = 0; i < 200 && got_q.size() < 5; i++)
      @(posedge clk);
    repeat (10) @(negedge clk);
    #1;
    start = 1;
    mask  = 16'h8000;
    @(negedge clk);
    #1;
    start = 0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 0;
    run   = 0;
    #1;
    chk("rst_mid",
        {busy, done, error, req_valid, req_write,
         exit_code, req_addr, req_wdata}, 0);
    chk("ignored_start", got_q.size(), 5);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    #1;
    chk("post_rst_idle", {busy, done, req_valid}, 0);
    eoc_q = '{32'h5};
    start_run(16'h0002, 64'h0000_0001_0000_0040, -1, 0);
    finish_run("t6");
    chk("t6_exit", exit_code, 31'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
